// File: rtl/pos_abs_scheduler_pkg.sv
// rtl/pos_abs_scheduler_pkg.sv - shared FSM encoding and width default for the position abs scheduler
//
// Purpose: single home for the scheduler state encoding and the default
// operand width used across the Position subsystem.
// Contents: W_DEF (default operand width), state_t (IDLE/CONV/OUT).
package pos_abs_scheduler_pkg;

    localparam int W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/pos_abs_scheduler_if.sv
// rtl/pos_abs_scheduler_if.sv - request/result bundle between position requesters and the abs scheduler
//
// Purpose: groups the per-requester valid/ready/data request side and the
// backpressured result side into one interface.
// Modports:
//   master - requesters + result consumer: drive req_valid, req_data, res_ready
//   slave  - scheduler: drives req_ready and all res_* fields
interface pos_abs_scheduler_if
    import pos_abs_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = W_DEF,
    parameter int IDW  = 2
);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_data;
    logic              res_sign;
    logic              res_sat;
    logic [IDW-1:0]    res_id;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_data, res_sign, res_sat, res_id
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_data, res_sign, res_sat, res_id
    );

endinterface

// File: rtl/pos_rr_arbiter.sv
// rtl/pos_rr_arbiter.sv - NREQ-way round-robin picker
//
// Purpose: picks the first valid requester at or after ptr, wrapping to 0.
// Ports:
//   valid  in  NREQ  request valid bits
//   ptr    in  IDW   highest-priority index this round
//   en     in  1     when low, no grant is produced
//   grant  out NREQ  one-hot grant (all-zero if none)
//   idx    out IDW   binary index of the grant (0 if none)
module pos_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic [IDW:0] sum;
    logic [IDW:0] cand;
    logic         found;

    // ptr < NREQ and k < NREQ, so a single conditional subtract is the modulo.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum  = {1'b0, ptr} + (IDW+1)'(k);
            cand = (sum >= (IDW+1)'(NREQ)) ? sum - (IDW+1)'(NREQ) : sum;
            if (en && !found && valid[cand[IDW-1:0]]) begin
                found                   = 1'b1;
                grant[cand[IDW-1:0]]    = 1'b1;
                idx                     = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/pos_abs_scheduler.sv
// rtl/pos_abs_scheduler.sv - shared signed-to-magnitude unit with round-robin request arbitration
//
// Purpose: accepts one two's-complement operand at a time from NREQ
// requesters, converts it to magnitude + sign (+ saturation for the most
// negative value) in a registered stage and presents it on a backpressured
// result port tagged with the requester id.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   bus  slave modport of pos_abs_scheduler_if (req_* in/ready out, res_* out/ready in)
module pos_abs_scheduler
    import pos_abs_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = W_DEF,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    pos_abs_scheduler_if.slave bus
);

    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  id_reg;
    logic [W-1:0]    op_reg;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            arb_en;
    logic            accept;
    logic [W-1:0]    grant_data;

    logic            res_valid;
    logic [W-1:0]    res_data;
    logic            res_sign;
    logic            res_sat;
    logic [IDW-1:0]  res_id;

    // Grants are only offered in IDLE and never while reset is held.
    assign arb_en = (state == ST_IDLE) && !rst;

    pos_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .valid (bus.req_valid),
        .ptr   (rr_ptr),
        .en    (arb_en),
        .grant (grant),
        .idx   (grant_idx)
    );

    // The arbiter only grants a valid requester, so any grant is an accept.
    assign accept        = |grant;
    assign bus.req_ready = grant;
    assign grant_data    = bus.req_data[grant_idx*W +: W];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_CONV;
            ST_CONV: state_nxt = ST_OUT;
            ST_OUT:  if (bus.res_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            op_reg    <= '0;
            id_reg    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sign  <= 1'b0;
            res_sat   <= 1'b0;
            res_id    <= '0;
        end else begin
            state     <= state_nxt;
            res_valid <= (state_nxt == ST_OUT);
            if (accept) begin
                op_reg <= grant_data;
                id_reg <= grant_idx;
                rr_ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
            end
            if (state == ST_CONV) begin
                res_sign <= op_reg[W-1];
                res_id   <= id_reg;
                // The most negative value has no positive counterpart; clamp it.
                if (op_reg == MIN_NEG) begin
                    res_data <= MAX_POS;
                    res_sat  <= 1'b1;
                end else if (op_reg[W-1]) begin
                    res_data <= ~op_reg + W'(1);
                    res_sat  <= 1'b0;
                end else begin
                    res_data <= op_reg;
                    res_sat  <= 1'b0;
                end
            end
        end
    end

    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;
    assign bus.res_sign  = res_sign;
    assign bus.res_sat   = res_sat;
    assign bus.res_id    = res_id;

endmodule
